// File: rtl/dlfloat16_mul_seq.sv
// Sequential DLFloat16 multiplier: ten shift-add steps over the significands,
// one normalise step, then a result held behind a valid/ready handshake.
module dlfloat16_mul_seq #(
    parameter int unsigned BIAS   = 31,
    parameter int unsigned MANT_W = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] c_mul,
    output logic [2:0]  flags
);

    localparam int unsigned EXP_W  = 15 - MANT_W;
    localparam int unsigned SIG_W  = MANT_W + 1;
    localparam int unsigned PROD_W = 2 * SIG_W;
    localparam int unsigned CNT_W  = $clog2(SIG_W + 1);
    localparam int unsigned E_W    = EXP_W + 2;

    localparam logic [EXP_W-1:0]      EXP_ALL1 = {EXP_W{1'b1}};
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SIG_W - 1);
    localparam logic signed [E_W-1:0] E_BIAS   = E_W'(BIAS);
    localparam logic signed [E_W-1:0] E_MAX    = E_W'((1 << EXP_W) - 2);
    localparam logic signed [E_W-1:0] E_ONE    = E_W'(1);

    typedef enum logic [1:0] {StIdle, StMul, StNorm, StDone} state_e;
    typedef enum logic [1:0] {ClsNormal, ClsNan, ClsInf, ClsZero} cls_e;

    state_e r_state, w_state_next;

    logic [SIG_W-1:0]  r_ma;
    logic [SIG_W-1:0]  r_mb;
    logic [PROD_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [EXP_W-1:0]  r_ea;
    logic [EXP_W-1:0]  r_eb;
    logic              r_sign;
    cls_e              r_cls;
    logic [15:0]       r_c_mul;
    logic [2:0]        r_flags;

    logic              w_a_zero, w_a_inf, w_a_nan;
    logic              w_b_zero, w_b_inf, w_b_nan;
    cls_e              w_cls;
    logic [PROD_W-1:0] w_mb_shift;
    logic signed [E_W-1:0] w_exp_sum;
    logic signed [E_W-1:0] w_exp_norm;
    logic [MANT_W-1:0] w_frac;
    logic [15:0]       w_res_c;
    logic [2:0]        w_res_f;
    logic              w_unused_acc;

    // Operand classification; a zero exponent flushes any fraction to zero.
    always_comb begin
        w_a_zero = (a[14:MANT_W] == '0);
        w_a_inf  = (a[14:MANT_W] == EXP_ALL1) && (a[MANT_W-1:0] == '0);
        w_a_nan  = (a[14:MANT_W] == EXP_ALL1) && (a[MANT_W-1:0] != '0);
        w_b_zero = (b[14:MANT_W] == '0);
        w_b_inf  = (b[14:MANT_W] == EXP_ALL1) && (b[MANT_W-1:0] == '0);
        w_b_nan  = (b[14:MANT_W] == EXP_ALL1) && (b[MANT_W-1:0] != '0);

        if (w_a_nan || w_b_nan || (w_a_zero && w_b_inf) || (w_a_inf && w_b_zero)) begin
            w_cls = ClsNan;
        end else if (w_a_inf || w_b_inf) begin
            w_cls = ClsInf;
        end else if (w_a_zero || w_b_zero) begin
            w_cls = ClsZero;
        end else begin
            w_cls = ClsNormal;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (in_valid) w_state_next = StMul;
            StMul:  if (r_cnt == CNT_LAST) w_state_next = StNorm;
            StNorm: w_state_next = StDone;
            StDone: if (out_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (r_state == StIdle);
        out_valid = (r_state == StDone);
        c_mul     = r_c_mul;
        flags     = r_flags;
    end

    assign w_mb_shift = PROD_W'(r_mb) << r_cnt;

    // Datapath: operand latch, shift-add accumulation, result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ma    <= '0;
            r_mb    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ea    <= '0;
            r_eb    <= '0;
            r_sign  <= 1'b0;
            r_cls   <= ClsNormal;
            r_c_mul <= '0;
            r_flags <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_ma   <= {1'b1, a[MANT_W-1:0]};
                        r_mb   <= {1'b1, b[MANT_W-1:0]};
                        r_ea   <= a[14:MANT_W];
                        r_eb   <= b[14:MANT_W];
                        r_sign <= a[15] ^ b[15];
                        r_cls  <= w_cls;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                    end
                end
                StMul: begin
                    if (r_ma[0]) begin
                        r_acc <= r_acc + w_mb_shift;
                    end
                    r_ma  <= r_ma >> 1;
                    r_cnt <= r_cnt + 1'b1;
                end
                StNorm: begin
                    r_c_mul <= w_res_c;
                    r_flags <= w_res_f;
                end
                default: ;
            endcase
        end
    end

    // Normalisation by truncation: the product significand lies in [1, 4).
    always_comb begin
        w_exp_sum = $signed(E_W'(r_ea)) + $signed(E_W'(r_eb)) - E_BIAS;
        if (r_acc[PROD_W-1]) begin
            w_frac     = r_acc[PROD_W-2 -: MANT_W];
            w_exp_norm = w_exp_sum + E_ONE;
        end else begin
            w_frac     = r_acc[PROD_W-3 -: MANT_W];
            w_exp_norm = w_exp_sum;
        end
    end

    // Low product bits fall below the truncation point.
    assign w_unused_acc = ^r_acc[PROD_W-MANT_W-3:0];

    always_comb begin
        w_res_c = '0;
        w_res_f = '0;
        unique case (r_cls)
            ClsNan: begin
                w_res_c = {r_sign, {EXP_W{1'b1}}, {MANT_W{1'b1}}};
                w_res_f = 3'b100;
            end
            ClsInf: begin
                w_res_c = {r_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            end
            ClsZero: begin
                w_res_c = {r_sign, 15'h0000};
            end
            default: begin
                if (w_exp_norm > E_MAX) begin
                    w_res_c = {r_sign, E_MAX[EXP_W-1:0], {MANT_W{1'b1}}};
                    w_res_f = 3'b010;
                end else if (w_exp_norm < E_ONE) begin
                    w_res_c = {r_sign, 15'h0000};
                    w_res_f = 3'b001;
                end else begin
                    w_res_c = {r_sign, w_exp_norm[EXP_W-1:0], w_frac};
                end
            end
        endcase
    end

endmodule

// File: tb/tb_dlfloat16_mul_seq.sv
// Scoreboard bench for dlfloat16_mul_seq: directed vectors with hand-computed
// products, latency, backpressure and mid-operation reset.
module tb_dlfloat16_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] c_mul;
    logic [2:0]  flags;

    typedef struct packed {
        logic [15:0] c;
        logic [2:0]  f;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    localparam int NV = 12;
    logic [15:0] va [NV] = '{16'h4000, 16'h3E00, 16'h0000, 16'h7E00, 16'h8000, 16'h7E05,
                             16'h7C00, 16'h0200, 16'h4100, 16'hBE00, 16'h0005, 16'h7E00};
    logic [15:0] vb [NV] = '{16'hC100, 16'h3E00, 16'hFE00, 16'h4000, 16'h4000, 16'h3E00,
                             16'h7C00, 16'h0200, 16'h4100, 16'hBE00, 16'h4000, 16'hFE00};
    logic [15:0] vc [NV] = '{16'hC300, 16'h3E00, 16'hFFFF, 16'h7E00, 16'h8000, 16'h7FFF,
                             16'h7DFF, 16'h0000, 16'h4440, 16'h3E00, 16'h0000, 16'hFE00};
    logic [2:0]  vf [NV] = '{3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b100,
                             3'b010, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};

    dlfloat16_mul_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_mul     (c_mul),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Monitor: pops one expected result per accepted output.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got c=%h f=%b want none", c_mul, flags);
            end else begin
                e = sb.pop_front();
                check("c_mul", 32'(c_mul), 32'(e.c));
                check("flags", 32'(flags), 32'(e.f));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [15:0] ia, input logic [15:0] ib,
                         input logic [15:0] ec, input logic [2:0] ef);
        int n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: in_ready got 0 want 1");
            return;
        end
        a        = ia;
        b        = ib;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sb.push_back('{c: ec, f: ef});
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int lat;
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_c_mul", 32'(c_mul), 32'h0000);
        check("rst_flags", 32'(flags), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency: in_valid presented, out_valid on the 12th rising edge.
        a        = 16'h3F00;
        b        = 16'h3F00;
        in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        #1;
        in_valid = 1'b0;
        sb.push_back('{c: 16'h4040, f: 3'b000});
        while (!out_valid && lat < 30) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check("latency", 32'(lat), 32'd12);
        drain();

        for (int i = 0; i < NV; i++) begin
            issue(va[i], vb[i], vc[i], vf[i]);
        end
        drain();

        // Backpressure with stray in_valid pulses during MUL.
        out_ready = 1'b0;
        issue(16'h3F00, 16'hC100, 16'hC240, 3'b000);
        repeat (3) @(posedge clk);
        #1;
        a        = 16'h7C00;
        b        = 16'h7C00;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_out_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_c_mul", 32'(c_mul), 32'hC240);
            check("bp_hold_flags", 32'(flags), 32'd0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        drain();

        // Reset in the middle of MUL, then a clean operation.
        issue(16'h3F00, 16'hC100, 16'hC240, 3'b000);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_c_mul", 32'(c_mul), 32'h0000);
        check("mid_rst_flags", 32'(flags), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(16'h3F00, 16'h3F00, 16'h4040, 3'b000);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
